player_physics: RTL and testbench

Per-frame player motion and game-state controller. Consumes the combinational collision flags computed from its own registered `player_x`/`player_y`, together with the debounced, synchronized buttons. Once per `frame_tick` it updates position, vertical velocity and game state, and its outputs feed both the collision block and the renderer.

---
 rtl/player_physics.sv | 202 ++++++++++++++++++++
 tb/tb_player_physics.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/player_physics.sv
// Per-frame player motion and PLAY/DEAD/WIN state controller, updated on frame_tick.
// Optional `PLAYER_DOUBLE_JUMP_EN adds a one-shot mid-air jump.
module player_physics #(
  parameter int START_X        = 20,
  parameter int START_Y        = 344,
  parameter int MOVE_SPD       = 2,
  parameter int GRAVITY        = 1,
  parameter int JUMP_VEL       = 10,
  parameter int MAX_FALL       = 8,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  input  logic              on_ground,
  input  logic [9:0]        support_y,
  input  logic              hit_ceiling,
  input  logic              hit_left_wall,
  input  logic              hit_right_wall,
  input  logic              at_goal_region,
  input  logic              in_lava,
  output logic [9:0]        player_x,
  output logic [9:0]        player_y,
  output logic signed [5:0] vel_y,
  output logic [1:0]        game_state,
  output logic              death_pulse
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_DEAD = 2'd1,
    ST_WIN  = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [10:0]        X_MAX   = 11'd624;
  localparam logic signed [10:0] Y_MAX   = 11'sd463;
  localparam logic signed [10:0] PLAYER_H = 11'sd16;
  localparam logic signed [7:0]  GRAV_S  = 8'(GRAVITY);
  localparam logic signed [7:0]  MAXF_S  = 8'(MAX_FALL);
  localparam logic signed [5:0]  JUMP_V  = 6'(-JUMP_VEL);
  localparam logic [CNT_W-1:0]   RESP_N  = CNT_W'(RESPAWN_FRAMES);

  function automatic logic [9:0] clamp_y(input logic signed [10:0] v);
    if (v < 11'sd0)       return 10'd0;
    else if (v > Y_MAX)   return Y_MAX[9:0];
    else                  return v[9:0];
  endfunction

  function automatic logic signed [5:0] sat_vel(input logic signed [7:0] v);
    if (v > 8'sd31)       return 6'sd31;
    else if (v < -8'sd32) return -6'sd32;
    else                  return v[5:0];
  endfunction

  state_e                  state_q, state_d;
  logic [9:0]              x_q, x_d, y_q, y_d;
  logic signed [5:0]       vel_q, vel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    death_q, death_d;
  logic                    jump_req_q, jump_req_d;
  logic                    btn_jump_q, btn_jump_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic                    air_jump_q, air_jump_d;
`endif

  logic                    jump_edge, jump_now;
  logic signed [10:0]      y_ext, v_ext, y_sum, y_snap;
  logic signed [7:0]       vg, vg_cap;
  logic [10:0]             x_add;

  always_comb begin
    jump_edge  = btn_jump & ~btn_jump_q;
    jump_now   = jump_req_q | jump_edge;
    btn_jump_d = btn_jump;
    jump_req_d = frame_tick ? 1'b0 : jump_now;

    y_ext  = {1'b0, y_q};
    v_ext  = {{5{vel_q[5]}}, vel_q};
    y_sum  = y_ext + v_ext;
    y_snap = $signed({1'b0, support_y}) - PLAYER_H;
    vg     = {{2{vel_q[5]}}, vel_q} + GRAV_S;
    vg_cap = (vg > MAXF_S) ? MAXF_S : vg;
    x_add  = {1'b0, x_q} + 11'(MOVE_SPD);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    death_d = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    air_jump_d = air_jump_q;
`endif

    if (frame_tick) begin
      case (state_q)
        ST_PLAY: begin
          if (in_lava) begin
            state_d = ST_DEAD;
            vel_d   = 6'sd0;
            cnt_d   = RESP_N;
            death_d = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_jump_d = 1'b0;
`endif
          end else if (at_goal_region && on_ground) begin
            state_d = ST_WIN;
            vel_d   = 6'sd0;
          end else begin
            if (btn_right && !btn_left && !hit_right_wall)
              x_d = (x_add > X_MAX) ? X_MAX[9:0] : x_add[9:0];
            else if (btn_left && !btn_right && !hit_left_wall)
              x_d = (x_q < 10'(MOVE_SPD)) ? 10'd0 : x_q - 10'(MOVE_SPD);

            if (on_ground && !vel_q[5]) begin
              y_d   = clamp_y(y_snap);
              vel_d = jump_now ? JUMP_V : 6'sd0;
`ifdef PLAYER_DOUBLE_JUMP_EN
              air_jump_d = 1'b1;
`endif
            end else begin
`ifdef PLAYER_DOUBLE_JUMP_EN
              // Mid-air jump replaces this tick's ceiling/gravity update; y holds.
              if (jump_now && air_jump_q) begin
                vel_d      = JUMP_V;
                air_jump_d = 1'b0;
              end else
`endif
              if (hit_ceiling && vel_q[5]) begin
                vel_d = 6'sd0;
              end else begin
                y_d   = clamp_y(y_sum);
                vel_d = sat_vel(vg_cap);
              end
            end
          end
        end
        ST_DEAD: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
          air_jump_d = 1'b0;
`endif
          if (cnt_q == '0) begin
            state_d = ST_PLAY;
            x_d     = 10'(START_X);
            y_d     = 10'(START_Y);
            vel_d   = 6'sd0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WIN: begin
          if (jump_now) begin
            state_d = ST_PLAY;
            x_d     = 10'(START_X);
            y_d     = 10'(START_Y);
            vel_d   = 6'sd0;
          end
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PLAY;
      x_q        <= 10'(START_X);
      y_q        <= 10'(START_Y);
      vel_q      <= 6'sd0;
      cnt_q      <= '0;
      death_q    <= 1'b0;
      jump_req_q <= 1'b0;
      btn_jump_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_jump_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      cnt_q      <= cnt_d;
      death_q    <= death_d;
      jump_req_q <= jump_req_d;
      btn_jump_q <= btn_jump_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_jump_q <= air_jump_d;
`endif
    end
  end

  assign player_x    = x_q;
  assign player_y    = y_q;
  assign vel_y       = vel_q;
  assign game_state  = state_q;
  assign death_pulse = death_q;

endmodule

// File: tb/tb_player_physics.sv
// Scoreboard bench for player_physics: ticks push expected state, a monitor checks after each tick.
module tb_player_physics;
  localparam int PLAY = 0, DEAD = 1, WIN = 2;

  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic on_ground = 1'b0, hit_ceiling = 1'b0, hit_left_wall = 1'b0, hit_right_wall = 1'b0;
  logic at_goal_region = 1'b0, in_lava = 1'b0;
  logic [9:0] support_y = 10'd360;
  logic [9:0] player_x, player_y;
  logic signed [5:0] vel_y;
  logic [1:0] game_state;
  logic death_pulse;

  player_physics dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .on_ground(on_ground), .support_y(support_y), .hit_ceiling(hit_ceiling),
    .hit_left_wall(hit_left_wall), .hit_right_wall(hit_right_wall),
    .at_goal_region(at_goal_region), .in_lava(in_lava),
    .player_x(player_x), .player_y(player_y), .vel_y(vel_y),
    .game_state(game_state), .death_pulse(death_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id; int x; int y; int v; int st; int dp;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0, n_total = 0, tick_id = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int v,
                           input int st, input int dp);
    int av;
    av = vel_y;
    check($sformatf("%s.x", tag), player_x, x);
    check($sformatf("%s.y", tag), player_y, y);
    check($sformatf("%s.vel", tag), av, v);
    check($sformatf("%s.state", tag), game_state, st);
    check($sformatf("%s.death", tag), death_pulse, dp);
  endtask

  // Monitor: outputs are valid one clk after each frame_tick.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick) begin
        #1;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: got output with no expected entry");
        end else begin
          e = sb.pop_front();
          check_all($sformatf("tick%0d", e.id), e.x, e.y, e.v, e.st, e.dp);
        end
      end
    end
  end

  task automatic tick(input int x, input int y, input int v, input int st,
                      input int dp, input bit jmp = 1'b0);
    repeat (3) @(negedge clk);
    sb.push_back('{tick_id, x, y, v, st, dp});
    tick_id++;
    frame_tick = 1'b1;
    if (jmp) btn_jump = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    btn_jump   = 1'b0;
  endtask

  task automatic jump_pulse();
    @(negedge clk) btn_jump = 1'b1;
    repeat (2) @(negedge clk);
    btn_jump = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, v;
    repeat (2) @(negedge clk);
    check_all("reset", 20, 344, 0, PLAY, 0);
    rst_n = 1'b1;

    // Walk right on the ground
    on_ground = 1'b1; support_y = 10'd360; btn_right = 1'b1;
    for (int i = 1; i <= 10; i++) tick(20 + 2*i, 344, 0, PLAY, 0);
    btn_right = 1'b0;

    // Jump arc through apex to terminal velocity, then land
    jump_pulse();
    tick(40, 344, -10, PLAY, 0);
    on_ground = 1'b0;
    y = 344; v = -10;
    for (int i = 0; i < 20; i++) begin
      y = y + v; v = (v + 1 > 8) ? 8 : v + 1;
      tick(40, y, v, PLAY, 0);
    end
    on_ground = 1'b1;
    tick(40, 344, 0, PLAY, 0);

    // Ceiling bump at vel -5, then wall blocking
    jump_pulse();
    tick(40, 344, -10, PLAY, 0);
    on_ground = 1'b0;
    y = 344; v = -10;
    for (int i = 0; i < 5; i++) begin
      y = y + v; v = v + 1;
      tick(40, y, v, PLAY, 0);
    end
    hit_ceiling = 1'b1;
    tick(40, 304, 0, PLAY, 0);
    hit_ceiling = 1'b0;
    btn_left = 1'b1; hit_left_wall = 1'b1;
    tick(40, 304, 1, PLAY, 0);
    hit_left_wall = 1'b0;
    tick(38, 305, 2, PLAY, 0);
    btn_left = 1'b0; on_ground = 1'b1;
    tick(38, 344, 0, PLAY, 0);

    // Left edge saturation at x=0
    btn_left = 1'b1; x = 38;
    for (int i = 0; i < 20; i++) begin
      x = (x >= 2) ? x - 2 : 0;
      tick(x, 344, 0, PLAY, 0);
    end
    btn_left = 1'b0;
    btn_right = 1'b1; hit_right_wall = 1'b1;
    tick(0, 344, 0, PLAY, 0);
    hit_right_wall = 1'b0; btn_left = 1'b1;
    tick(0, 344, 0, PLAY, 0);
    btn_left = 1'b0; btn_right = 1'b0;

    // Free fall clamps at y=463
    on_ground = 1'b0; y = 344; v = 0;
    for (int i = 0; i < 20; i++) begin
      y = (y + v > 463) ? 463 : y + v; v = (v + 1 > 8) ? 8 : v + 1;
      tick(0, y, v, PLAY, 0);
    end
    on_ground = 1'b1;
    tick(0, 344, 0, PLAY, 0);

    // Jump edge in the same cycle as the tick
    tick(0, 344, -10, PLAY, 0, 1'b1);

    // Lava, respawn countdown with buttons ignored
    in_lava = 1'b1;
    tick(0, 344, 0, DEAD, 1);
    in_lava = 1'b0;
    @(negedge clk);
    check("death_one_clk", death_pulse, 0);
    btn_right = 1'b1;
    for (int i = 0; i < 60; i++) tick(0, 344, 0, DEAD, 0);
    tick(20, 344, 0, PLAY, 0);

    // Goal: walk, win, frozen, jump to respawn
    for (int i = 1; i <= 5; i++) tick(20 + 2*i, 344, 0, PLAY, 0);
    btn_right = 1'b0; at_goal_region = 1'b1;
    tick(30, 344, 0, WIN, 0);
    btn_right = 1'b1;
    tick(30, 344, 0, WIN, 0);
    btn_right = 1'b0; btn_left = 1'b1;
    tick(30, 344, 0, WIN, 0);
    btn_left = 1'b0; at_goal_region = 1'b0;
    jump_pulse();
    tick(20, 344, 0, PLAY, 0);

    // Airborne jumps: one extra with double jump, none without
    tick(20, 344, 0, PLAY, 0);
    jump_pulse();
    tick(20, 344, -10, PLAY, 0);
    on_ground = 1'b0;
    tick(20, 334, -9, PLAY, 0);
    jump_pulse();
`ifdef PLAYER_DOUBLE_JUMP_EN
    tick(20, 334, -10, PLAY, 0);
    tick(20, 324, -9, PLAY, 0);
    jump_pulse();
    tick(20, 315, -8, PLAY, 0);
`else
    tick(20, 325, -8, PLAY, 0);
    tick(20, 317, -7, PLAY, 0);
    jump_pulse();
    tick(20, 310, -6, PLAY, 0);
`endif

    // Asynchronous reset mid-jump, then a normal tick
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 20, 344, 0, PLAY, 0);
    @(negedge clk) rst_n = 1'b1;
    on_ground = 1'b1;
    tick(20, 344, 0, PLAY, 0);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
